// File: rtl/noc_pkg.sv
// Shared defaults, flit layout and elaboration helpers for the NOC
// per-PE local-port buffer.
package noc_pkg;

   localparam int DefDataWidth = 8;
   localparam int DefViCh      = 2;
   localparam int DefViChAddr  = 1;
   localparam int DefDepth     = 4;

   typedef struct packed {
      logic [DefViChAddr-1:0]  sel;
      logic [DefDataWidth-1:0] data;
   } flit_t;

   // Ceiling log2 for elaboration-time sizing; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/noc_vc_port_buffer_if.sv
// One valid/ready flit link with a virtual-channel select; the master drives
// the flit and the slave drives Ready.
interface noc_vc_port_buffer_if import noc_pkg::*; #(
   parameter int DataWidth = DefDataWidth,
   parameter int ViChAddr  = DefViChAddr
);

   logic [DataWidth-1:0] Data;
   logic                 En;
   logic [ViChAddr-1:0]  Sel;
   logic                 Ready;

   modport master (output Data, output En, output Sel, input Ready);
   modport slave  (input Data, input En, input Sel, output Ready);

endinterface

// File: rtl/vc_fifo_bank.sv
// Bank of per-VC FIFOs with a write-side Ready decode and a round-robin read
// arbiter that locks its grant while an offered flit is not accepted.
module vc_fifo_bank import noc_pkg::*; #(
   parameter int DataWidth = DefDataWidth,
   parameter int ViCh      = DefViCh,
   parameter int ViChAddr  = DefViChAddr,
   parameter int Depth     = DefDepth
) (
   input logic                  clock,
   input logic                  reset,
   noc_vc_port_buffer_if.slave  wr,
   noc_vc_port_buffer_if.master rd
);

   localparam int DepthAddr = clog2(Depth);
   localparam int CountW    = DepthAddr + 1;

   logic [DataWidth-1:0] mem   [ViCh][Depth];
   logic [DepthAddr-1:0] wrPtr [ViCh];
   logic [DepthAddr-1:0] rdPtr [ViCh];
   logic [CountW-1:0]    count [ViCh];

   logic [ViChAddr-1:0]  rrPtr;
   logic [ViChAddr-1:0]  heldVc;
   logic [ViChAddr-1:0]  grant;
   logic                 held;
   logic                 anyValid;
   logic                 wrXfer;
   logic                 rdXfer;
   logic [ViCh-1:0]      nonEmpty;
   logic [ViCh-1:0]      full;
   logic [ViCh-1:0]      pushVc;
   logic [ViCh-1:0]      popVc;
   logic [DataWidth-1:0] grantData;

   always_comb begin
      for (int i = 0; i < ViCh; i++) begin
         nonEmpty[i] = (count[i] != '0);
         full[i]     = (count[i] == CountW'(Depth));
      end
   end

   // NOTE: Ready depends only on the registered count, so a pop in the same
   // cycle cannot reopen a full VC; out-of-range Sel matches no VC.
   always_comb begin
      wr.Ready = 1'b0;
      for (int i = 0; i < ViCh; i++) begin
         if (wr.Sel == ViChAddr'(i)) begin
            wr.Ready = !reset && !full[i];
         end
      end
   end

   assign wrXfer = wr.En && wr.Ready;

   // A held grant wins outright; otherwise search cyclically from rrPtr.
   always_comb begin
      grant    = heldVc;
      anyValid = held;
      if (!held) begin
         grant = '0;
         for (int k = 0; k < ViCh; k++) begin
            for (int i = 0; i < ViCh; i++) begin
               if (!anyValid && nonEmpty[i] && (((int'(rrPtr) + k) % ViCh) == i)) begin
                  anyValid = 1'b1;
                  grant    = ViChAddr'(i);
               end
            end
         end
      end
   end

   assign rdXfer = anyValid && rd.Ready;

   always_comb begin
      grantData = '0;
      popVc     = '0;
      pushVc    = '0;
      for (int i = 0; i < ViCh; i++) begin
         if (grant == ViChAddr'(i)) begin
            grantData = mem[i][rdPtr[i]];
            popVc[i]  = rdXfer;
         end
         pushVc[i] = wrXfer && (wr.Sel == ViChAddr'(i));
      end
   end

   assign rd.En   = anyValid;
   assign rd.Data = anyValid ? grantData : '0;
   assign rd.Sel  = anyValid ? grant : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ViCh; i++) begin
            wrPtr[i] <= '0;
            rdPtr[i] <= '0;
            count[i] <= '0;
         end
         rrPtr  <= '0;
         held   <= 1'b0;
         heldVc <= '0;
      end else begin
         for (int i = 0; i < ViCh; i++) begin
            if (pushVc[i]) wrPtr[i] <= wrPtr[i] + DepthAddr'(1);
            if (popVc[i])  rdPtr[i] <= rdPtr[i] + DepthAddr'(1);
            if (pushVc[i] && !popVc[i]) begin
               count[i] <= count[i] + CountW'(1);
            end else if (!pushVc[i] && popVc[i]) begin
               count[i] <= count[i] - CountW'(1);
            end
         end
         if (rdXfer) begin
            held  <= 1'b0;
            rrPtr <= (int'(grant) == ViCh - 1) ? '0 : grant + ViChAddr'(1);
         end else if (anyValid) begin
            held   <= 1'b1;
            heldVc <= grant;
         end
      end
   end

   // NOTE: storage is deliberately not reset; counts and pointers alone decide
   // which entries are live, so stale contents are never presented.
   always_ff @(posedge clock) begin
      for (int i = 0; i < ViCh; i++) begin
         if (pushVc[i]) mem[i][wrPtr[i]] <= wr.Data;
      end
   end

endmodule

// File: rtl/noc_vc_port_buffer.sv
// Per-PE local-port buffer: an egress bank (PE to router) and an ingress bank
// (router to PE), each with one FIFO per virtual channel.
module noc_vc_port_buffer import noc_pkg::*; #(
   parameter int DataWidth = DefDataWidth,
   parameter int ViCh      = DefViCh,
   parameter int ViChAddr  = DefViChAddr,
   parameter int Depth     = DefDepth
) (
   input logic                  clock,
   input logic                  reset,
   noc_vc_port_buffer_if.slave  PE_Outp,
   noc_vc_port_buffer_if.master NOC_Inp,
   noc_vc_port_buffer_if.slave  NOC_Outp,
   noc_vc_port_buffer_if.master PE_Inp
);

   vc_fifo_bank #(
      .DataWidth (DataWidth),
      .ViCh      (ViCh),
      .ViChAddr  (ViChAddr),
      .Depth     (Depth)
   ) egress (
      .clock (clock),
      .reset (reset),
      .wr    (PE_Outp),
      .rd    (NOC_Inp)
   );

   vc_fifo_bank #(
      .DataWidth (DataWidth),
      .ViCh      (ViCh),
      .ViChAddr  (ViChAddr),
      .Depth     (Depth)
   ) ingress (
      .clock (clock),
      .reset (reset),
      .wr    (NOC_Outp),
      .rd    (PE_Inp)
   );

endmodule

// File: tb/tb_noc_vc_port_buffer.sv
// Bench for noc_vc_port_buffer: directed scenarios plus random traffic, checked
// each cycle against a queue-based model of both links.
module tb_noc_vc_port_buffer;
   import noc_pkg::*;

   localparam int VC  = 2;
   localparam int DEP = 4;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   noc_vc_port_buffer_if #(.DataWidth(8), .ViChAddr(1)) peOutp  ();
   noc_vc_port_buffer_if #(.DataWidth(8), .ViChAddr(1)) nocInp  ();
   noc_vc_port_buffer_if #(.DataWidth(8), .ViChAddr(1)) nocOutp ();
   noc_vc_port_buffer_if #(.DataWidth(8), .ViChAddr(1)) peInp   ();

   noc_vc_port_buffer #(.DataWidth(8), .ViCh(VC), .ViChAddr(1), .Depth(DEP)) dut (
      .clock    (clock),
      .reset    (reset),
      .PE_Outp  (peOutp),
      .NOC_Inp  (nocInp),
      .NOC_Outp (nocOutp),
      .PE_Inp   (peInp)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model: per link and VC, the queue of accepted flits (index link*VC+vc).
   logic [7:0] mq [2*VC][$];
   int         rr      [2];
   bit         held    [2];
   int         heldSel [2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkLink(input int l, input logic wEn, input int wSel, input logic [7:0] wData,
                            input logic wRdy, input logic rEn, input logic [7:0] rData,
                            input int rSel, input logic rRdy);
      string pfx;
      bit    expRdy;
      bit    expEn;
      int    s;
      logic [7:0] expData;
      pfx    = (l == 0) ? "egress" : "ingress";
      expRdy = !reset && (wSel < VC) && (mq[l*VC+wSel].size() < DEP);
      check({pfx, ".wrReady"}, 32'(wRdy), 32'(expRdy));

      expEn = held[l];
      s     = held[l] ? heldSel[l] : 0;
      if (!held[l]) begin
         for (int k = 0; k < VC; k++) begin
            int v;
            v = (rr[l] + k) % VC;
            if (!expEn && mq[l*VC+v].size() > 0) begin
               expEn = 1'b1;
               s     = v;
            end
         end
      end
      expData = expEn ? mq[l*VC+s][0] : 8'h00;
      check({pfx, ".rdEn"},   32'(rEn),   32'(expEn));
      check({pfx, ".rdData"}, 32'(rData), 32'(expData));
      check({pfx, ".rdSel"},  32'(rSel),  expEn ? 32'(s) : 32'd0);

      // Apply what the coming rising edge will do.
      if (reset) begin
         for (int v = 0; v < VC; v++) mq[l*VC+v].delete();
         rr[l]   = 0;
         held[l] = 1'b0;
      end else begin
         if (expEn && rRdy) begin
            void'(mq[l*VC+s].pop_front());
            rr[l]   = (s + 1) % VC;
            held[l] = 1'b0;
         end else if (expEn) begin
            held[l]    = 1'b1;
            heldSel[l] = s;
         end
         if (wEn && expRdy) mq[l*VC+wSel].push_back(wData);
      end
   endtask

   always @(negedge clock) begin
      checkLink(0, peOutp.En, int'(peOutp.Sel), peOutp.Data, peOutp.Ready,
                nocInp.En, nocInp.Data, int'(nocInp.Sel), nocInp.Ready);
      checkLink(1, nocOutp.En, int'(nocOutp.Sel), nocOutp.Data, nocOutp.Ready,
                peInp.En, peInp.Data, int'(peInp.Sel), peInp.Ready);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic peWrite(input logic sel, input logic [7:0] data);
      peOutp.En   = 1'b1;
      peOutp.Sel  = sel;
      peOutp.Data = data;
      tick();
      peOutp.En   = 1'b0;
   endtask

   task automatic nocWrite(input logic sel, input logic [7:0] data);
      nocOutp.En   = 1'b1;
      nocOutp.Sel  = sel;
      nocOutp.Data = data;
      tick();
      nocOutp.En   = 1'b0;
   endtask

   initial begin
      flit_t f;
      checks = 0;
      errors = 0;
      for (int l = 0; l < 2; l++) begin
         rr[l] = 0; held[l] = 1'b0; heldSel[l] = 0;
      end
      reset = 1'b1;
      peOutp.En = 1'b0;  peOutp.Sel = 1'b0;  peOutp.Data = 8'h00;
      nocOutp.En = 1'b0; nocOutp.Sel = 1'b0; nocOutp.Data = 8'h00;
      nocInp.Ready = 1'b0;
      peInp.Ready  = 1'b0;
      repeat (2) tick();
      reset = 1'b0;

      // Single flit, one-cycle latency.
      nocInp.Ready = 1'b1;
      peWrite(1'b0, 8'hA1);
      repeat (2) tick();

      // Fill VC1 while stalled, probe Ready per VC, then drain.
      nocInp.Ready = 1'b0;
      for (int i = 0; i < 4; i++) peWrite(1'b1, 8'(8'h10 + i));
      peOutp.Sel = 1'b1; tick();
      peOutp.Sel = 1'b0; tick();
      nocInp.Ready = 1'b1;
      repeat (6) tick();

      // Interleaving of two VCs.
      nocInp.Ready = 1'b0;
      peWrite(1'b0, 8'h01); peWrite(1'b0, 8'h02);
      peWrite(1'b1, 8'h81); peWrite(1'b1, 8'h82);
      nocInp.Ready = 1'b1;
      repeat (6) tick();

      // Hold lock: a late VC0 flit must not preempt the offered VC1 flit.
      nocInp.Ready = 1'b0;
      peWrite(1'b1, 8'h55);
      tick();
      peWrite(1'b0, 8'h66);
      repeat (2) tick();
      nocInp.Ready = 1'b1;
      repeat (3) tick();

      // Ingress flit held stable while the PE stalls.
      peInp.Ready = 1'b0;
      nocWrite(1'b1, 8'h3C);
      repeat (3) tick();
      peInp.Ready = 1'b1;
      repeat (2) tick();

      // Reset with flits queued, then one fresh flit.
      nocInp.Ready = 1'b0;
      peWrite(1'b0, 8'h11); peWrite(1'b1, 8'h22); peWrite(1'b0, 8'h33);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      nocInp.Ready = 1'b1;
      peWrite(1'b0, 8'h7E);
      repeat (3) tick();

      // Random traffic on both paths, with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         f.sel  = 1'($urandom_range(0, 1));
         f.data = 8'($urandom);
         peOutp.En    = ($urandom_range(0, 9) < 6);
         peOutp.Sel   = f.sel;
         peOutp.Data  = f.data;
         nocOutp.En   = ($urandom_range(0, 9) < 6);
         nocOutp.Sel  = 1'($urandom_range(0, 1));
         nocOutp.Data = 8'($urandom);
         nocInp.Ready = ($urandom_range(0, 9) < 5);
         peInp.Ready  = ($urandom_range(0, 9) < 7);
         reset        = ($urandom_range(0, 299) == 0);
         tick();
      end

      // Drain both paths and confirm they go idle.
      reset = 1'b0;
      peOutp.En = 1'b0; nocOutp.En = 1'b0;
      nocInp.Ready = 1'b1; peInp.Ready = 1'b1;
      repeat (20) tick();
      @(negedge clock);
      #1;
      check("egress.idle",  32'(nocInp.En), 32'd0);
      check("ingress.idle", 32'(peInp.En),  32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
